// File: rtl/door_pkg.sv
// door_pkg: shared FSM state type and attempts counter width for the door lock.
package door_pkg;
    typedef enum logic [1:0] {IDLE, OPEN, LOCKOUT} state_t;
    localparam int ATT_W = 2;
endpackage

// File: rtl/door_timer.sv
// door_timer: loadable down-counter that holds at zero and flags it.
module door_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         en,
    output logic         zero
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= load_value;
        else if (en && cnt != '0) cnt <= cnt - W'(1);
    end
    assign zero = cnt == '0;
endmodule

// File: rtl/door_lock_ctrl.sv
// door_lock_ctrl: keypad door lock with timed unlock, retry counting and lockout.
// Define DOOR_ALARM_EN to drive alarm during lockout; otherwise alarm is tied low.
module door_lock_ctrl
    import door_pkg::*;
#(
    parameter int UNLOCK_CYCLES  = 16,
    parameter int MAX_FAIL       = 3,
    parameter int LOCKOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enter,
    input  logic             z,
    output logic             unlock,
    output logic             fail,
    output logic             locked_out,
    output logic [ATT_W-1:0] attempts_left,
    output logic             alarm
);
    localparam int MAX_CYC = UNLOCK_CYCLES > LOCKOUT_CYCLES ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW = $clog2(MAX_CYC + 1);
    localparam logic [TW-1:0] UNLOCK_LD = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LD = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [ATT_W-1:0] ATT_MAX = ATT_W'(MAX_FAIL);

    state_t           state, state_n;
    logic             enter_q, submit, ld, tmr_zero, fail_n;
    logic [TW-1:0]    ld_val;
    logic [ATT_W-1:0] att_n;

    assign submit = enter & ~enter_q;

    door_timer #(.W(TW)) u_timer (
        .clk(clk),
        .rst(rst),
        .load(ld),
        .load_value(ld_val),
        .en(state != IDLE),
        .zero(tmr_zero)
    );

    always_comb begin
        state_n = state;
        att_n   = attempts_left;
        ld      = 1'b0;
        ld_val  = '0;
        fail_n  = 1'b0;
        case (state)
            IDLE: if (submit) begin
                ld = 1'b1;
                if (z) begin
                    state_n = OPEN;
                    ld_val  = UNLOCK_LD;
                    att_n   = ATT_MAX;
                end else begin
                    fail_n  = 1'b1;
                    att_n   = attempts_left - ATT_W'(1);
                    state_n = attempts_left <= ATT_W'(1) ? LOCKOUT : IDLE;
                    ld_val  = LOCK_LD;
                end
            end
            OPEN: state_n = tmr_zero ? IDLE : OPEN;
            LOCKOUT: if (tmr_zero) begin
                state_n = IDLE;
                att_n   = ATT_MAX;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            enter_q       <= 1'b1;
            unlock        <= 1'b0;
            fail          <= 1'b0;
            locked_out    <= 1'b0;
            attempts_left <= ATT_MAX;
        end else begin
            state         <= state_n;
            enter_q       <= enter;
            unlock        <= state_n == OPEN;
            fail          <= fail_n;
            locked_out    <= state_n == LOCKOUT;
            attempts_left <= att_n;
        end
    end

`ifdef DOOR_ALARM_EN
    // A submission during lockout holds the alarm one cycle past the lockout edge.
    always_ff @(posedge clk) begin
        if (rst) alarm <= 1'b0;
        else alarm <= (state_n == LOCKOUT) | (state == LOCKOUT & submit);
    end
`else
    assign alarm = 1'b0;
`endif
endmodule

// File: doc/door_lock_ctrl.md
DOOR_LOCK_CTRL -- requirements
Module: door_lock_ctrl

Interface
REQ-001 Parameter UNLOCK_CYCLES, 16, number of cycles unlock SHALL stay asserted after a correct code (legal 1..65535).
REQ-002 Parameter MAX_FAIL, 3, consecutive wrong submissions that SHALL trigger lockout (legal 1..3).
REQ-003 Parameter LOCKOUT_CYCLES, 64, lockout duration in cycles (legal 1..65535).
REQ-004 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 enter  input  1  code-submit level from keypad; rising edge = one submission.
REQ-007 z  input  1  code-match flag from the serial pattern detector, sampled on the submit cycle.
REQ-008 unlock  output  1  door strike drive, registered.
REQ-009 fail  output  1  one-cycle pulse per rejected submission, registered.
REQ-010 locked_out  output  1  high throughout LOCKOUT, registered.
REQ-011 attempts_left  output  2  remaining tries before lockout, registered.
REQ-012 alarm  output  1  alarm drive (see Configuration).

Function
REQ-013 submit SHALL be enter & ~enter_q, with enter_q a 1-cycle registered copy of enter; z SHALL be sampled in that same cycle, before the detector clears.
REQ-014 States SHALL be IDLE, OPEN, LOCKOUT; all outputs SHALL be registered (asserted the cycle after the transition).
REQ-015 IDLE + submit + z=1 -> OPEN; timer loaded UNLOCK_CYCLES-1; attempts_left reloaded to MAX_FAIL.
REQ-016 IDLE + submit + z=0 with attempts_left>1 -> stay IDLE; attempts_left decrements by 1; fail pulses 1 cycle.
REQ-017 IDLE + submit + z=0 with attempts_left==1 -> LOCKOUT; fail pulses; attempts_left becomes 0; timer loaded LOCKOUT_CYCLES-1.
REQ-018 OPEN: unlock=1 for exactly UNLOCK_CYCLES cycles, then IDLE; submissions during OPEN SHALL be ignored (no fail, no count change).
REQ-019 LOCKOUT: locked_out=1 for exactly LOCKOUT_CYCLES cycles, then IDLE with attempts_left=MAX_FAIL; submissions ignored.
REQ-020 Timer SHALL be a down-counter of width $clog2(max(UNLOCK_CYCLES,LOCKOUT_CYCLES)+1); state exits when timer==0; no wrap below 0.
REQ-021 enter held high continuously SHALL produce exactly one submission.
REQ-022 z without a submit edge SHALL have no effect in any state.
REQ-023 unlock and locked_out SHALL never be high in the same cycle.

Reset
REQ-024 On rst=1 at a posedge: state=IDLE, unlock=0, fail=0, locked_out=0, alarm=0, attempts_left=MAX_FAIL, timer=0, enter_q=1.
REQ-025 enter_q reset to 1 SHALL suppress a false submission when enter is high while reset releases.
REQ-026 rst asserted mid-OPEN or mid-LOCKOUT SHALL abort immediately to the reset values, with no lingering unlock or locked_out.

Configuration
REQ-027 Macro DOOR_ALARM_EN defined: alarm=1 throughout LOCKOUT, plus one extra cycle on any submission attempted during LOCKOUT.
REQ-028 DOOR_ALARM_EN undefined: alarm port SHALL remain and be tied to 0; all other behaviour identical.

Structure
REQ-029 Shared package door_pkg SHALL hold the state typedef (IDLE/OPEN/LOCKOUT) and the attempts_left width constant.
REQ-030 Timer SHALL be a sub-module door_timer (load, load_value, count-enable, zero flag), instantiated once and shared by OPEN and LOCKOUT.

Verification (bench params: UNLOCK_CYCLES=4, MAX_FAIL=3, LOCKOUT_CYCLES=8)
REQ-031 Correct code: z=1 and enter rises at cycle 10 -> unlock high cycles 11-14, low at cycle 15; attempts_left=3.
REQ-032 Three wrong codes: z=0, three enter edges -> fail pulse on each; attempts_left 2,1,0; locked_out high 8 cycles; then attempts_left=3.
REQ-033 Ignore while busy: enter edge with z=1 during OPEN, and with z=0 during LOCKOUT -> no fail pulse, no timer extension, attempts_left unchanged.
REQ-034 Held enter: enter high for 20 cycles with z=0 -> exactly one fail pulse; attempts_left=2.
REQ-035 Reset mid-operation: rst at cycle 2 of OPEN, with enter high -> unlock=0 next cycle, state IDLE, no submission after release until enter falls and rises again.
REQ-036 DOOR_ALARM_EN: run once defined and once undefined -> alarm mirrors LOCKOUT, plus its extra pulse, or stays 0.
